cpu_axi_master: RTL and testbench

- Upstream neighbour of the CPU CSR register file. Converts the CPU core's simple load/store burst requests into AXI4 master transactions on the CSR slave's s_axi_* bus.
- Carries one outstanding transaction at a time and supports INCR bursts of 32-bit words.
- Returns read data and write responses to the core on ready/valid streams.

---
 rtl/cpu_axi_master_if.sv | 111 +++++++++++
 rtl/cpu_axi_master.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_axi_master.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_master_if.sv
// Bundle of the core-side request/data/response streams and the AXI4 master
// channels of cpu_axi_master. The master modport is the bridge's view; the
// slave modport is the view of whatever sits on the other side of every stream.
interface cpu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  // core request stream
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic [ID_W-1:0]   req_id;
  // core write-data stream
  logic              wd_valid;
  logic              wd_ready;
  logic [31:0]       wd_data;
  logic [3:0]        wd_strb;
  // core read-data stream
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic [1:0]        rd_resp;
  // core write-response / error stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_resp;
  logic [ID_W-1:0]   rsp_id;
  // AXI read address
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [ID_W-1:0]   m_axi_arid;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  // AXI write address
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [ID_W-1:0]   m_axi_awid;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  // AXI write data
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  // AXI read data
  logic [31:0]       m_axi_rdata;
  logic [ID_W-1:0]   m_axi_rid;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  // AXI write response
  logic [ID_W-1:0]   m_axi_bid;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  // status
  logic              busy;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_id,
    output req_ready,
    input  wd_valid, wd_data, wd_strb,
    output wd_ready,
    output rd_valid, rd_data, rd_last, rd_resp,
    input  rd_ready,
    output rsp_valid, rsp_resp, rsp_id,
    input  rsp_ready,
    output m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    output m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_id,
    input  req_ready,
    output wd_valid, wd_data, wd_strb,
    input  wd_ready,
    input  rd_valid, rd_data, rd_last, rd_resp,
    output rd_ready,
    input  rsp_valid, rsp_resp, rsp_id,
    output rsp_ready,
    input  m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    input  m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  busy
  );
endinterface

// File: rtl/cpu_axi_master.sv
// Bridge from the core's load/store burst requests to a single-outstanding
// AXI4 INCR master. Bad requests (misaligned, too long, crossing 4 KB) are
// answered locally with SLVERR and never reach the bus.
module cpu_axi_master #(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_LEN = 16
) (
  input  logic              m_aclk,
  input  logic              m_areset,
  cpu_axi_master_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ERR, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              arvalid_q, arvalid_d;
  logic              awvalid_q, awvalid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        in_rdata, in_wdata;
  logic        req_fire, r_fire, w_fire, b_fire, rsp_fire;
  logic        cnt_at_len;
  logic [10:0] span;
  logic        req_bad;

  assign in_rdata   = (state_q == RDATA);
  assign in_wdata   = (state_q == WDATA);
  assign cnt_at_len = (cnt_q == len_q);

  // Handshakes; R/B/W are only honoured in their own states.
  assign req_fire = bus.req_valid && req_ready_q;
  assign r_fire   = in_rdata && bus.m_axi_rvalid && bus.rd_ready;
  assign w_fire   = in_wdata && bus.wd_valid && bus.m_axi_wready;
  assign b_fire   = bus.m_axi_bvalid && bus.m_axi_bready;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  // Last word index of the burst within its 4 KB page; 11 bits so overflow shows.
  assign span    = {1'b0, bus.req_addr[11:2]} + {3'b000, bus.req_len};
  assign req_bad = (bus.req_addr[1:0] != 2'b00) ||
                   ({1'b0, bus.req_len} >= MAX_LEN_W) ||
                   (span > 11'd1023);

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_id_d    = rsp_id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        req_ready_d = !req_fire;
        if (req_fire) begin
          addr_d = bus.req_addr;
          len_d  = bus.req_len;
          id_d   = bus.req_id;
          cnt_d  = 8'd0;
          if (req_bad) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = RESP_SLVERR;
            rsp_id_d    = bus.req_id;
          end else if (bus.req_write) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (rsp_fire) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      RADDR: begin
        if (bus.m_axi_arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
        end
      end
      RDATA: begin
        if (r_fire) begin
          cnt_d = cnt_q + 8'd1;
          // A missing rlast is closed off at the requested beat count.
          if (bus.m_axi_rlast || cnt_at_len) begin
            state_d     = IDLE;
            cnt_d       = 8'd0;
            req_ready_d = 1'b1;
          end
        end
      end
      WADDR: begin
        if (bus.m_axi_awready) begin
          state_d   = WDATA;
          awvalid_d = 1'b0;
        end
      end
      WDATA: begin
        if (w_fire) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_at_len) begin
            state_d = WRESP;
            cnt_d   = 8'd0;
          end
        end
      end
      WRESP: begin
        if (b_fire) begin
          rsp_valid_d = 1'b1;
          rsp_resp_d  = (bus.m_axi_bid != id_q) ? RESP_SLVERR : bus.m_axi_bresp;
          rsp_id_d    = id_q;
        end else if (rsp_fire) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge m_aclk) begin
    if (m_areset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_id_q    <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      id_q        <= '0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_id_q    <= rsp_id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = (state_q != IDLE);

  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arid    = id_q;
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;

  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awid    = id_q;
  assign bus.m_axi_awlen   = len_q;
  assign bus.m_axi_awsize  = 3'b010;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = awvalid_q;

  // Write data is a straight pass-through gated by the WDATA state.
  assign bus.m_axi_wvalid = in_wdata && bus.wd_valid;
  assign bus.wd_ready     = in_wdata && bus.m_axi_wready;
  assign bus.m_axi_wdata  = bus.wd_data;
  assign bus.m_axi_wstrb  = bus.wd_strb;
  assign bus.m_axi_wlast  = in_wdata && cnt_at_len;

  // Read data passes through; ID mismatch or a truncated burst flags SLVERR.
  assign bus.m_axi_rready = in_rdata && bus.rd_ready;
  assign bus.rd_valid     = in_rdata && bus.m_axi_rvalid;
  assign bus.rd_data      = in_rdata ? bus.m_axi_rdata : 32'd0;
  assign bus.rd_last      = in_rdata && (bus.m_axi_rlast || cnt_at_len);
  assign bus.rd_resp      = !in_rdata ? 2'b00 :
                            ((bus.m_axi_rid != id_q) || (cnt_at_len && !bus.m_axi_rlast)) ?
                            RESP_SLVERR : bus.m_axi_rresp;

  assign bus.m_axi_bready = (state_q == WRESP) && !rsp_valid_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed scoreboard bench for cpu_axi_master: the bench plays both the core
// and a simple AXI slave with a word memory.
module tb_cpu_axi_master;
  localparam int ADDR_W = 32;
  localparam int ID_W = 4;
  localparam int MAX_LEN = 16;

  typedef struct packed { logic [31:0] data; logic last; logic [1:0] resp; } rbeat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
  typedef struct packed { logic [1:0] resp; logic [3:0] id; } rsp_t;

  logic clk = 1'b0;
  logic m_areset = 1'b1;
  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] wbuf [0:15];
  rbeat_t rexp[$];
  wbeat_t wexp[$];
  rsp_t sexp[$];

  always #5 clk = ~clk;

  cpu_axi_master_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  cpu_axi_master #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_LEN(MAX_LEN)) dut (
    .m_aclk(clk), .m_areset(m_areset), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int cyc = 0;
    txn++;
    $display("txn %0d: %s addr=0x%08h len=%0d id=%0d", txn, wr ? "WRITE" : "READ", addr, len, id);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_len = len; bus.req_id = id;
    @(negedge clk);
    while (!bus.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // AR/AW phase; R/B/W stimulus is held active to prove it is ignored here.
  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, input int delay);
    int seen = 0; int cyc = 0; logic done = 1'b0; logic v = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      bus.m_axi_rvalid = 1'b1; bus.rd_ready = 1'b1; bus.m_axi_bvalid = 1'b1; bus.wd_valid = 1'b1;
      if (wr) bus.m_axi_awready = (seen >= delay); else bus.m_axi_arready = (seen >= delay);
      @(negedge clk); cyc++;
      chk("rready_outside", bus.m_axi_rready, 1'b0);
      chk("bready_outside", bus.m_axi_bready, 1'b0);
      chk("wvalid_before_aw", bus.m_axi_wvalid, 1'b0);
      chk("rd_valid_outside", bus.rd_valid, 1'b0);
      chk("other_valid", wr ? bus.m_axi_arvalid : bus.m_axi_awvalid, 1'b0);
      v = wr ? bus.m_axi_awvalid : bus.m_axi_arvalid;
      if (seen > 0) chk("addr_valid_hold", v, 1'b1);
      if (v) begin
        chk("axaddr", wr ? bus.m_axi_awaddr : bus.m_axi_araddr, addr);
        chk("axlen", wr ? bus.m_axi_awlen : bus.m_axi_arlen, len);
        chk("axid", wr ? bus.m_axi_awid : bus.m_axi_arid, id);
        chk("axsize", wr ? bus.m_axi_awsize : bus.m_axi_arsize, 3'b010);
        chk("axburst", wr ? bus.m_axi_awburst : bus.m_axi_arburst, 2'b01);
        if (wr ? bus.m_axi_awready : bus.m_axi_arready) done = 1'b1;
        seen++;
      end
    end
    chk("addr_handshake", v, 1'b1);
    @(posedge clk); #1;
    bus.m_axi_arready = 1'b0; bus.m_axi_awready = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.rd_ready = 1'b0; bus.m_axi_bvalid = 1'b0; bus.wd_valid = 1'b0;
  endtask

  task automatic run_read(input int nbeats, input logic send_rlast, input logic [3:0] rid, input int base, input logic rnd);
    int b = 0; int cyc = 0; rbeat_t e; logic [9:0] idx;
    while (b < nbeats && cyc < 300) begin
      @(posedge clk); #1;
      idx = 10'(base + b);
      bus.m_axi_rvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_axi_rdata = mem[idx]; bus.m_axi_rid = rid; bus.m_axi_rresp = 2'b00;
      bus.m_axi_rlast = send_rlast && (b == nbeats - 1);
      @(negedge clk); cyc++;
      if (bus.m_axi_rvalid && bus.rd_ready) begin
        chk("rready", bus.m_axi_rready, 1'b1);
        if (rexp.size() == 0) chk("rd_unexpected", bus.rd_valid, 1'b0);
        else begin
          e = rexp.pop_front();
          chk("rd_valid", bus.rd_valid, 1'b1);
          chk("rd_data", bus.rd_data, e.data);
          chk("rd_last", bus.rd_last, e.last);
          chk("rd_resp", bus.rd_resp, e.resp);
        end
        b++;
      end else if (bus.m_axi_rvalid) begin
        chk("rready_stall", bus.m_axi_rready, 1'b0);
        chk("rd_data_stall", bus.rd_data, mem[idx]);
      end else begin
        chk("rd_valid_gap", bus.rd_valid, 1'b0);
      end
    end
    chk("read_beats", b, nbeats);
    @(posedge clk); #1;
    bus.m_axi_rvalid = 1'b0; bus.rd_ready = 1'b0; bus.m_axi_rlast = 1'b0;
    @(negedge clk);
    chk("busy_after_read", bus.busy, 1'b0);
  endtask

  task automatic run_wdata(input int nbeats, input int base, input logic rnd);
    int b = 0; int cyc = 0; wbeat_t e; logic [9:0] idx; logic [3:0] bi;
    while (b < nbeats && cyc < 300) begin
      @(posedge clk); #1;
      bi = 4'(b);
      bus.wd_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_axi_wready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wd_data = wbuf[bi]; bus.wd_strb = 4'hF;
      @(negedge clk); cyc++;
      if (bus.wd_valid && bus.m_axi_wready) begin
        chk("wd_ready", bus.wd_ready, 1'b1);
        if (wexp.size() == 0) chk("w_unexpected", bus.m_axi_wvalid, 1'b0);
        else begin
          e = wexp.pop_front();
          chk("wvalid", bus.m_axi_wvalid, 1'b1);
          chk("wdata", bus.m_axi_wdata, e.data);
          chk("wstrb", bus.m_axi_wstrb, e.strb);
          chk("wlast", bus.m_axi_wlast, e.last);
        end
        idx = 10'(base + b);
        mem[idx] = bus.m_axi_wdata;
        b++;
      end else if (bus.wd_valid) begin
        chk("wd_ready_stall", bus.wd_ready, 1'b0);
        chk("wvalid_stall", bus.m_axi_wvalid, 1'b1);
      end else begin
        chk("wvalid_gap", bus.m_axi_wvalid, 1'b0);
      end
    end
    chk("write_beats", b, nbeats);
    @(posedge clk); #1;
    bus.wd_valid = 1'b0; bus.m_axi_wready = 1'b0;
  endtask

  task automatic run_bresp(input logic [3:0] bid, input logic [1:0] bresp);
    int cyc = 0; logic done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      bus.m_axi_bvalid = 1'b1; bus.m_axi_bid = bid; bus.m_axi_bresp = bresp;
      @(negedge clk); cyc++;
      if (bus.m_axi_bready) done = 1'b1;
    end
    chk("bready", bus.m_axi_bready, 1'b1);
    @(posedge clk); #1;
    bus.m_axi_bvalid = 1'b0;
  endtask

  // Holds rsp_ready low for one valid cycle to check the response is stable.
  task automatic run_rsp();
    int cyc = 0; int seen = 0; logic done = 1'b0; rsp_t e = '0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      bus.rsp_ready = (seen >= 1);
      @(negedge clk); cyc++;
      chk("arvalid_quiet", bus.m_axi_arvalid, 1'b0);
      chk("awvalid_quiet", bus.m_axi_awvalid, 1'b0);
      if (bus.rsp_valid) begin
        if (seen == 0) begin
          if (sexp.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 1'b0);
          else e = sexp.pop_front();
        end
        chk("rsp_resp", bus.rsp_resp, e.resp);
        chk("rsp_id", bus.rsp_id, e.id);
        chk("busy_in_rsp", bus.busy, 1'b1);
        if (bus.rsp_ready) done = 1'b1;
        seen++;
      end
    end
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_rsp", bus.busy, 1'b0);
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.req_id = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wd_strb = '0; bus.rd_ready = 1'b0; bus.rsp_ready = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_rdata = '0; bus.m_axi_rid = '0; bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_bid = '0; bus.m_axi_bresp = '0; bus.m_axi_bvalid = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A50000 ^ (32'(i) * 32'h01010101);
    mem[2] = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_resp", bus.rsp_resp, 2'b00);
    chk("rst_rd_resp", bus.rd_resp, 2'b00);
    @(posedge clk); #1;
    m_areset = 1'b0;
    @(negedge clk);
    chk("req_ready_release", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1'b1);

    // Single read
    rexp.push_back('{data: 32'hDEADBEEF, last: 1'b1, resp: 2'b00});
    do_req(1'b0, 32'h08, 8'd0, 4'd3);
    addr_phase(1'b0, 32'h08, 8'd0, 4'd3, 0);
    run_read(1, 1'b1, 4'd3, 2, 1'b0);

    // 4-beat write with delayed AW
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'(i + 1);
      wexp.push_back('{data: 32'(i + 1), strb: 4'hF, last: (i == 3)});
    end
    sexp.push_back('{resp: 2'b00, id: 4'd5});
    do_req(1'b1, 32'h10, 8'd3, 4'd5);
    addr_phase(1'b1, 32'h10, 8'd3, 4'd5, 2);
    run_wdata(4, 4, 1'b0);
    run_bresp(4'd5, 2'b00);
    run_rsp();

    // Readback of the same four words
    for (int i = 0; i < 4; i++) rexp.push_back('{data: 32'(i + 1), last: (i == 3), resp: 2'b00});
    do_req(1'b0, 32'h10, 8'd3, 4'd6);
    addr_phase(1'b0, 32'h10, 8'd3, 4'd6, 1);
    run_read(4, 1'b1, 4'd6, 4, 1'b0);

    // Rejected requests: misaligned, 4 KB crossing, too long
    sexp.push_back('{resp: 2'b10, id: 4'd7});
    do_req(1'b0, 32'h0E, 8'd0, 4'd7);
    run_rsp();
    sexp.push_back('{resp: 2'b10, id: 4'd8});
    do_req(1'b1, 32'hFFC, 8'd1, 4'd8);
    run_rsp();
    sexp.push_back('{resp: 2'b10, id: 4'd9});
    do_req(1'b0, 32'h0, 8'd16, 4'd9);
    run_rsp();

    // 8-beat write and read under random backpressure
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = $urandom;
      wexp.push_back('{data: wbuf[i], strb: 4'hF, last: (i == 7)});
    end
    sexp.push_back('{resp: 2'b00, id: 4'd10});
    do_req(1'b1, 32'h40, 8'd7, 4'd10);
    addr_phase(1'b1, 32'h40, 8'd7, 4'd10, 1);
    run_wdata(8, 16, 1'b1);
    run_bresp(4'd10, 2'b00);
    run_rsp();
    for (int i = 0; i < 8; i++) rexp.push_back('{data: wbuf[i], last: (i == 7), resp: 2'b00});
    do_req(1'b0, 32'h40, 8'd7, 4'd11);
    addr_phase(1'b0, 32'h40, 8'd7, 4'd11, 0);
    run_read(8, 1'b1, 4'd11, 16, 1'b1);

    // Reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 32'h100 + 32'(i);
      wexp.push_back('{data: 32'h100 + 32'(i), strb: 4'hF, last: (i == 3)});
    end
    do_req(1'b1, 32'h80, 8'd3, 4'd12);
    addr_phase(1'b1, 32'h80, 8'd3, 4'd12, 0);
    run_wdata(2, 32, 1'b0);
    wexp.delete();
    @(posedge clk); #1;
    m_areset = 1'b1; bus.wd_valid = 1'b1; bus.m_axi_wready = 1'b1;
    bus.m_axi_rvalid = 1'b1; bus.rd_ready = 1'b1; bus.m_axi_bvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("mid_rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("mid_rst_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_bready", bus.m_axi_bready, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_req_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    m_areset = 1'b0; bus.wd_valid = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_rvalid = 1'b0; bus.rd_ready = 1'b0; bus.m_axi_bvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("req_ready_after_rst", bus.req_ready, 1'b1);
    rexp.push_back('{data: 32'hDEADBEEF, last: 1'b1, resp: 2'b00});
    do_req(1'b0, 32'h08, 8'd0, 4'd13);
    addr_phase(1'b0, 32'h08, 8'd0, 4'd13, 0);
    run_read(1, 1'b1, 4'd13, 2, 1'b0);

    // Slave never raises rlast on a 3-beat read
    rexp.push_back('{data: mem[8], last: 1'b0, resp: 2'b00});
    rexp.push_back('{data: mem[9], last: 1'b0, resp: 2'b00});
    rexp.push_back('{data: mem[10], last: 1'b1, resp: 2'b10});
    do_req(1'b0, 32'h20, 8'd2, 4'd14);
    addr_phase(1'b0, 32'h20, 8'd2, 4'd14, 0);
    run_read(3, 1'b0, 4'd14, 8, 1'b0);

    // Wrong RID on a read beat
    rexp.push_back('{data: mem[9], last: 1'b1, resp: 2'b10});
    do_req(1'b0, 32'h24, 8'd0, 4'd1);
    addr_phase(1'b0, 32'h24, 8'd0, 4'd1, 0);
    run_read(1, 1'b1, 4'd2, 9, 1'b0);

    // Wrong BID on a write response
    wbuf[0] = 32'hCAFE0001;
    wexp.push_back('{data: 32'hCAFE0001, strb: 4'hF, last: 1'b1});
    sexp.push_back('{resp: 2'b10, id: 4'd4});
    do_req(1'b1, 32'h30, 8'd0, 4'd4);
    addr_phase(1'b1, 32'h30, 8'd0, 4'd4, 0);
    run_wdata(1, 12, 1'b0);
    run_bresp(4'd5, 2'b00);
    run_rsp();

    chk("rexp_left", rexp.size(), 0);
    chk("wexp_left", wexp.size(), 0);
    chk("sexp_left", sexp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
